// File: rtl/fetch_pkg.sv
// Shared fetch-path constants, the next-PC FSM state type and the target alignment helper.
package fetch_pkg;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned STEP = 4;
  localparam logic [ADDR_W-1:0] RESET_NPC = 9'd4;

  typedef enum logic [1:0] {
    SEQ  = 2'd0,
    PEND = 2'd1,
    SLOT = 2'd2
  } npc_state_e;

  // Word-align a byte address; low bits are dropped silently rather than trapped.
  function automatic logic [ADDR_W-1:0] align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential address incrementer; wraps modulo 2^ADDR_W. Shared with the jal link-address path.
module pc_incr #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned STEP   = 4
) (
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] pc_o
);

  assign pc_o = pc_i + ADDR_W'(STEP);

endmodule

// File: rtl/npc_sequencer.sv
// nPC register and delayed-branch sequencer feeding the PC register's pc_in.
module npc_sequencer
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] pc_next,
  output logic [ADDR_W-1:0] npc_out,
  output logic              le_pc,
  output logic              le_npc,
  output logic              in_delay_slot,
  output logic              redirect_err
);

  npc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] npc_inc_s;
  logic [ADDR_W-1:0] target_s;
  logic              req_s;

  pc_incr #(
    .ADDR_W(ADDR_W),
    .STEP  (STEP)
  ) u_pc_incr (
    .pc_i(npc_q),
    .pc_o(npc_inc_s)
  );

  always_comb begin
    req_s    = jump | branch_taken;
    target_s = align(jump ? jump_target : branch_target);

    state_d = state_q;
    npc_d   = npc_q;
    pend_d  = pend_q;
    err_d   = err_q;

    case (state_q)
      SEQ: begin
        if (!stall && req_s) begin
          npc_d   = target_s;
          state_d = SLOT;
        end else if (!stall) begin
          npc_d = npc_inc_s;
        end else if (req_s) begin
          pend_d  = target_s;
          state_d = PEND;
        end else begin
          state_d = SEQ;
        end
      end
      PEND: begin
        // Only one redirect may be outstanding; later ones are dropped and flagged.
        if (req_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (!stall) begin
          npc_d   = pend_q;
          state_d = SLOT;
        end else begin
          state_d = PEND;
        end
      end
      SLOT: begin
        // Target already sits in npc_q; it reaches PC on this edge, so no step here.
        if (req_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (!stall) begin
          state_d = SEQ;
        end else begin
          state_d = SLOT;
        end
      end
      default: begin
        state_d = SEQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ;
      npc_q   <= RESET_NPC;
      pend_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  assign pc_next       = npc_q;
  assign npc_out       = npc_q;
  assign le_pc         = ~stall;
  assign le_npc        = ~stall;
  assign in_delay_slot = (state_q == SLOT);
  assign redirect_err  = err_q;

endmodule

// File: tb/tb_npc_sequencer.sv
// Directed bench for npc_sequencer with a behavioural PC register downstream.
module tb_npc_sequencer;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic         branch_taken;
  logic [W-1:0] branch_target;
  logic         jump;
  logic [W-1:0] jump_target;
  logic [W-1:0] pc_next;
  logic [W-1:0] npc_out;
  logic         le_pc;
  logic         le_npc;
  logic         in_delay_slot;
  logic         redirect_err;
  logic [W-1:0] pc_reg;

  int n_checks = 0;
  int n_errors = 0;

  npc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .pc_next      (pc_next),
    .npc_out      (npc_out),
    .le_pc        (le_pc),
    .le_npc       (le_npc),
    .in_delay_slot(in_delay_slot),
    .redirect_err (redirect_err)
  );

  always #5 clk = ~clk;

  // Downstream PC register: resets to 0, loads pc_next when enabled.
  always @(posedge clk) begin
    if (reset) pc_reg <= '0;
    else if (le_pc) pc_reg <= pc_next;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    jump_target = '0; branch_target = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick();
    check_val("rst_pc_next", pc_next, 32'd4);
    check_val("rst_npc_out", npc_out, 32'd4);
    check_val("rst_slot", in_delay_slot, 32'd0);
    check_val("rst_err", redirect_err, 32'd0);
    check_val("rst_pc_reg", pc_reg, 32'd0);
    check_val("rst_le_pc", le_pc, 32'd1);
    check_val("rst_le_npc", le_npc, 32'd1);

    // 1: plain sequential fetch
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val("seq_pc_next", pc_next, 32'(4 + 4 * k));
      check_val("seq_pc_reg", pc_reg, 32'(4 * k));
    end

    // 3: taken branch at npc=20 with one delay slot
    tick();
    check_val("pre_br_npc", pc_next, 32'd20);
    check_val("pre_br_pc", pc_reg, 32'd16);
    branch_taken = 1'b1; branch_target = 9'h040;
    tick();
    check_val("br_pc_next", pc_next, 32'h40);
    check_val("br_slot", in_delay_slot, 32'd1);
    check_val("br_pc_slot", pc_reg, 32'd20);
    idle();
    tick();
    check_val("br_pc_target", pc_reg, 32'h40);
    check_val("br_slot_exit", in_delay_slot, 32'd0);
    check_val("br_no_err", redirect_err, 32'd0);

    // 2: sequential wrap at the top of the address space
    do_reset();
    for (int k = 0; k < 126; k++) tick();
    check_val("wrap_pre", npc_out, 32'd508);
    tick();
    check_val("wrap_npc", npc_out, 32'd0);
    check_val("wrap_err", redirect_err, 32'd0);

    // 4: jump during stall, held, then released; target realigned
    do_reset();
    stall = 1'b1; jump = 1'b1; jump_target = 9'h101;
    #1;
    check_val("stall_le_pc", le_pc, 32'd0);
    check_val("stall_le_npc", le_npc, 32'd0);
    tick();
    check_val("pend_hold0", pc_next, 32'd4);
    check_val("pend_slot0", in_delay_slot, 32'd0);
    jump = 1'b0; jump_target = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_val("pend_hold", pc_next, 32'd4);
      check_val("pend_pc_reg", pc_reg, 32'd0);
    end
    stall = 1'b0;
    tick();
    check_val("pend_release", pc_next, 32'h100);
    check_val("pend_rel_slot", in_delay_slot, 32'd1);
    check_val("pend_rel_pc", pc_reg, 32'd4);
    tick();
    check_val("pend_pc_target", pc_reg, 32'h100);
    check_val("pend_no_err", redirect_err, 32'd0);

    // 5: jump beats branch; branch in the delay slot is flagged and sticky
    do_reset();
    jump = 1'b1; jump_target = 9'h080;
    branch_taken = 1'b1; branch_target = 9'h040;
    tick();
    check_val("prio_npc", pc_next, 32'h80);
    check_val("prio_slot", in_delay_slot, 32'd1);
    check_val("prio_err0", redirect_err, 32'd0);
    jump = 1'b0; branch_target = 9'h0c0;
    tick();
    check_val("slot_br_err", redirect_err, 32'd1);
    check_val("slot_br_ignored", pc_reg, 32'h80);
    check_val("slot_exit", in_delay_slot, 32'd0);
    idle();
    for (int k = 0; k < 3; k++) tick();
    check_val("err_sticky", redirect_err, 32'd1);

    // 7: second redirect while pending keeps first target; release-cycle req ignored
    do_reset();
    check_val("err_cleared", redirect_err, 32'd0);
    stall = 1'b1; jump = 1'b1; jump_target = 9'h0c0;
    tick();
    jump = 1'b0; branch_taken = 1'b1; branch_target = 9'h040;
    tick();
    check_val("pend2_err", redirect_err, 32'd1);
    stall = 1'b0; branch_target = 9'h060;
    tick();
    check_val("pend2_first_kept", pc_next, 32'hc0);
    check_val("pend2_slot", in_delay_slot, 32'd1);

    // 6: reset while pending discards the captured target
    do_reset();
    stall = 1'b1; jump = 1'b1; jump_target = 9'h1f0;
    tick();
    jump = 1'b0; branch_taken = 1'b1; branch_target = 9'h020;
    tick();
    check_val("pend_err_set", redirect_err, 32'd1);
    reset = 1'b1; branch_taken = 1'b0; jump = 1'b1;
    tick();
    check_val("rst_pend_npc", pc_next, 32'd4);
    check_val("rst_pend_slot", in_delay_slot, 32'd0);
    check_val("rst_pend_err", redirect_err, 32'd0);
    reset = 1'b0;
    idle();
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val("rst_pend_seq", pc_next, 32'(4 + 4 * k));
      check_val("rst_pend_noslot", in_delay_slot, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
